mb8_acc: RTL and testbench
==========================

// Module: mb8_acc
// PURPOSE
//   Downstream accumulator for the registered 8b Booth multiplier stage. Consumes
//   signed 2*WIDTH-bit products, sums TERMS of them into one dot-product result,
//   presents it on a valid/ready output. Sits between the multiplier and the
//   SoC result buffer.
// PARAMETERS
//   WIDTH  8   operand width of the upstream multiplier; product is 2*WIDTH bits
//   TERMS  16  products summed per result (>=1)
//   ACC_W  20  accumulator/result width; default >= 2*WIDTH+clog2(TERMS) (no overflow)
// PORTS
//   CLK        in   1         clock, all state on posedge
//   RST        in   1         synchronous, active-high reset
//   in_valid   in   1         product1 carries a valid product this cycle
//   product1   in   2*WIDTH   signed two's-complement product from multiplier stage
//   in_ready   out  1         accumulator accepts a product this cycle
//   out_valid  out  1         acc_out holds a completed result
//   out_ready  in   1         consumer takes result this cycle
//   acc_out    out  ACC_W     signed result (registered)
//   busy       out  1         partial sum in progress (state ACC)
//   ovf        out  1         sticky saturation flag for current result
// BEHAVIOUR
//   - Reset: state=IDLE, acc=0, cnt=0, acc_out=0, out_valid=0, ovf=0, busy=0;
//     in_ready=1 the cycle after RST deasserts. Reset mid-op discards partial sum.
//   - Accept = in_valid & in_ready. product1 sign-extended to ACC_W before add.
//   - in_ready is combinational from state: 1 in IDLE/ACC, 0 in DONE.
//   - FSM:
//     IDLE: on accept acc<=sext(p), cnt<=1 -> ACC (-> DONE if TERMS==1).
//     ACC : on accept acc<=acc+sext(p), cnt<=cnt+1; when accept with cnt==TERMS-1
//           -> DONE, acc_out<=final sum. No accept: hold, no timeout.
//     DONE: out_valid=1; acc_out/ovf stable; product1 ignored.
//           out_valid&out_ready -> IDLE; out_valid drops next cycle.
//   - Latency: out_valid rises the cycle after the TERMS-th accept.
//     Throughput: one result per TERMS+1 cycles minimum (DONE costs 1 cycle).
//   - acc_out keeps last result after handshake until next DONE entry.
//   - cnt width clog2(TERMS)+1; never exceeds TERMS-1 in ACC.
//   - ovf cleared on entry to ACC from IDLE; valid only with out_valid.
// CONFIGURATION
//   ACC_SAT_EN defined: each add saturates to signed ACC_W max/min
//     (2^(ACC_W-1)-1 / -2^(ACC_W-1)); any clamp sets ovf, held until handshake.
//   ACC_SAT_EN undefined: two's-complement wrap at ACC_W bits; ovf tied to 0.
// TESTING
//   1 RST=1 two cycles -> out_valid=0, in_ready=1, acc_out=0, ovf=0, busy=0.
//   2 16 back-to-back products 100 -> out_valid the cycle after 16th accept, acc_out=1600, ovf=0.
//   3 8x(+300) then 8x(-500), with idle gaps between -> acc_out=-1600 (20'hFF9C0).
//   4 In DONE hold out_ready=0 5 cycles, drive in_valid=1 -> in_ready=0, acc_out stable, no accept.
//   5 7 products of 1000, RST pulse, 16 products of 1 -> acc_out=16, one out_valid only.
//   6 ACC_W=16, 16x(-128*-128=16384): with ACC_SAT_EN acc_out=32767, ovf=1; without acc_out=0, ovf=0.

Source files
------------

// File: rtl/mb8_acc.sv
// Accumulates TERMS signed products into one dot-product result behind a valid/ready output.
// Optional ACC_SAT_EN: saturating adds with a sticky ovf flag; otherwise wrap and ovf=0.
module mb8_acc #(
  parameter int WIDTH = 8,
  parameter int TERMS = 16,
  parameter int ACC_W = 20
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] product1,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               busy,
  output logic               ovf
);

  localparam int CNT_W = $clog2(TERMS) + 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                   state_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_out_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic                     out_valid_reg;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic                     accept;
  logic                     last_term;

  assign p_ext     = ACC_W'($signed(product1));
  assign in_ready  = (state_reg != DONE);
  assign accept    = in_valid & in_ready;
  assign last_term = (cnt_reg == CNT_W'(TERMS - 1));

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_wide;
  logic                  clamp;
  logic                  ovf_reg;

  // One guard bit: the two top bits disagree exactly when the add overflowed.
  assign sum_wide = {acc_reg[ACC_W-1], acc_reg} + {p_ext[ACC_W-1], p_ext};
  assign clamp    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
  assign sum_next = !clamp ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? SAT_MIN : SAT_MAX);
  assign ovf      = ovf_reg;
`else
  assign sum_next = acc_reg + p_ext;
  assign ovf      = 1'b0;
`endif

  assign out_valid = out_valid_reg;
  assign acc_out   = acc_out_reg;
  assign busy      = (state_reg == ACC);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      acc_out_reg   <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
`ifdef ACC_SAT_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_reg <= p_ext;
            cnt_reg <= CNT_W'(1);
`ifdef ACC_SAT_EN
            ovf_reg <= 1'b0;
`endif
            if (TERMS == 1) begin
              state_reg     <= DONE;
              acc_out_reg   <= p_ext;
              out_valid_reg <= 1'b1;
              cnt_reg       <= '0;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
`ifdef ACC_SAT_EN
            if (clamp) ovf_reg <= 1'b1;
`endif
            if (last_term) begin
              state_reg     <= DONE;
              acc_out_reg   <= sum_next;
              out_valid_reg <= 1'b1;
              cnt_reg       <= '0;
            end
          end
        end
        DONE: begin
          // Result and flag stay frozen until the consumer takes them.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb8_acc.sv
// Directed bench for mb8_acc: scoreboard of expected results checked on each output handshake.
module tb_mb8_acc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [15:0] product1;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] acc_out;
  logic        busy;
  logic        ovf;

  logic        b_in_valid;
  logic [15:0] b_product1;
  logic        b_in_ready;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_acc_out;
  logic        b_busy;
  logic        b_ovf;

  int vectors = 0;
  int miscompares = 0;
  int n_results = 0;
  logic [20:0] exp_q[$];

  always #5 CLK = ~CLK;

  mb8_acc dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .product1(product1),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .busy(busy), .ovf(ovf)
  );

  mb8_acc #(.WIDTH(8), .TERMS(16), .ACC_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .product1(b_product1),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_out(b_acc_out), .busy(b_busy), .ovf(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one product and return at the negedge after it has been accepted.
  task automatic send(input logic [15:0] p);
    int n = 0;
    in_valid = 1'b1;
    product1 = p;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
  endtask

  // Output monitor: a handshake completes at the next posedge.
  always begin
    @(negedge CLK);
    #1;
    if (!RST && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {11'd0, ovf, acc_out}, 32'hFFFFFFFF);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("result", {11'd0, ovf, acc_out}, {11'd0, e});
        $display("result acc_out=%0h ovf=%0b expected=%0h", acc_out, ovf, e);
      end
    end
  end

  initial begin
    int n;
    int base;
    logic [19:0] held;
    RST = 1'b1; in_valid = 1'b0; product1 = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_product1 = '0; b_out_ready = 1'b0;

    // 1: reset state
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_acc_out", {12'd0, acc_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 2: 16 back-to-back products of 100, latency check
    exp_q.push_back({1'b0, 20'd1600});
    for (int i = 0; i < 16; i++) begin
      send(16'd100);
      if (i == 14) begin
        chk("t2_busy_mid", {31'd0, busy}, 32'd1);
        chk("t2_not_done_early", {31'd0, out_valid}, 32'd0);
      end
    end
    chk("t2_out_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("t2_acc_out", {12'd0, acc_out}, 32'd1600);

    // 4: stall in DONE with in_valid high; nothing may be accepted
    held = acc_out;
    in_valid = 1'b1; product1 = 16'd999;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_acc_stable", {12'd0, acc_out}, {12'd0, held});
      chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("t4_out_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t4_acc_kept", {12'd0, acc_out}, 32'd1600);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);

    // 3: 8x(+300), 8x(-500) with idle gaps
    exp_q.push_back({1'b0, 20'hFF9C0});
    for (int i = 0; i < 16; i++) begin
      send(i < 8 ? 16'd300 : 16'hFE0C);
      in_valid = 1'b0;
      if (i % 3 == 0) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);

    // 5: partial sum discarded by reset, exactly one result afterwards
    for (int i = 0; i < 7; i++) send(16'd1000);
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t5_out_valid_after_rst", {31'd0, out_valid}, 32'd0);
    base = n_results;
    exp_q.push_back({1'b0, 20'd16});
    for (int i = 0; i < 16; i++) send(16'd1);
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    chk("t5_one_result", n_results - base, 32'd1);

    // 6: narrow accumulator, 16 x 16384
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_product1 = 16'h4000;
    repeat (16) @(negedge CLK);
    b_in_valid = 1'b0;
    chk("t6_out_valid", {31'd0, b_out_valid}, 32'd1);
`ifdef ACC_SAT_EN
    chk("t6_acc_out", {16'd0, b_acc_out}, 32'h7FFF);
    chk("t6_ovf", {31'd0, b_ovf}, 32'd1);
`else
    chk("t6_acc_out", {16'd0, b_acc_out}, 32'h0000);
    chk("t6_ovf", {31'd0, b_ovf}, 32'd0);
`endif
    $display("narrow acc_out=%0h ovf=%0b", b_acc_out, b_ovf);
    b_out_ready = 1'b1;
    @(negedge CLK);
    chk("t6_out_valid_drop", {31'd0, b_out_valid}, 32'd0);

    // Drain the scoreboard with a bounded wait
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("result_count", n_results, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
